sbox_lookup_pipe: RTL and testbench
===================================

# sbox_lookup_pipe

Parametrised, pipelined AES byte-substitution engine, successor to the fixed four-byte combinational T-table lookup. It processes LANES 32-bit columns per transaction in one of four modes: forward S-box, T-table fold (SubBytes followed by MixColumns per column), inverse S-box, or bypass. It uses a valid/ready handshake and a configurable register depth, and it sits between the round-state register and the AddRoundKey stage of the round datapath.

## Interface
- LANES, 4, number of 32-bit columns per transaction (1..8)
- DEPTH, 2, pipeline register stages (1..4)
- TAG_W, 4, width of sideband tag carried alongside data (>=1)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input transaction present
- in_ready  out  1  engine accepts input this cycle
- in_mode  in  2  0=SUB, 1=TBL, 2=INV, 3=BYPASS
- in_data  in  32*LANES  columns; lane k = bits [32k+31:32k]; byte 0 of a column = bits [31:24]
- in_tag  in  TAG_W  opaque sideband, returned unchanged
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_data  out  32*LANES  result columns, same lane/byte order
- out_tag  out  TAG_W  tag of the transaction on out_data
- occupancy  out  $clog2(DEPTH+1)  count of valid stages

## Operation
- Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Mode, data and tag are captured together at accept and travel as one token.
- SUB: each byte b -> S(b).
- INV: each byte b -> InvS(b).
- TBL: per column with input bytes s0..s3, let t_i = S(s_i):
  - r0 = 2t0^3t1^t2^t3
  - r1 = t0^2t1^3t2^t3
  - r2 = t0^t1^2t2^3t3
  - r3 = 3t0^t1^t2^2t3
  - 2t comes from the xS table; 3t = 2t^t. This equals the XOR of the four rotated T-table words.
- BYPASS: data passes unchanged.
- All lookup/fold logic is combinational ahead of stage 1. Stages 2..DEPTH are pure delay.
- Stage i holds v[i], data, tag. Stage DEPTH drives the out_* ports.
- Backpressure: stage i loads when ~v[i] | adv[i+1], where adv[DEPTH] = out_ready.
  - in_ready = ~v[1] | adv[2] (for DEPTH=1: ~v[1] | out_ready).
  - Combinational ready path; no bubbles; throughput one token per cycle.
- occupancy = popcount(v); range 0..DEPTH.
- Data registers load only on stage advance and hold while stalled. out_data/out_tag are stable while out_valid & ~out_ready.

## Timing
- Latency DEPTH cycles, accept to out_valid, with out_ready held high.
- Reset values:
  - all v = 0, out_valid = 0, out_data = 0, out_tag = 0, occupancy = 0
  - in_ready = 1 one cycle after reset
- Full pipe (occupancy = DEPTH) with out_ready = 0: in_ready = 0, and no token is dropped or duplicated.
- Full pipe with out_ready = 1: simultaneous accept and emit; occupancy unchanged.
- Empty pipe with in_valid = 0: out_valid = 0; registered data is don't-care but held.
- Mode may change every transaction. There is no mode-switch penalty.
- Reset asserted mid-operation flushes every token immediately (asynchronous). No output transfers after reset asserts.
- in_valid while in_ready = 0 is not accepted. The source must hold it.

## Structure
- Shared package aes_pkg:
  - mode enum (MODE_SUB, MODE_TBL, MODE_INV, MODE_BYPASS)
  - byte-order helper functions
  - gf_xtime function, used only for checking in the bench
- Sub-module aes_byte_lut: 8-bit in; outputs S, xS and InvS (three constant case tables).
- Instantiation: 4*LANES instances of aes_byte_lut, selected by mode per column.
- Top-level: stage register array generated over DEPTH.

## Test plan
- Reset then SUB with LANES=4, data 0x00000000_53535353_0000FFFF_01020304 -> out 0x63636363_EDEDEDED_63631616_7C777BF2 after DEPTH cycles, occupancy 1 -> 0.
- TBL, column 0x00525252 -> 0xC66363A5; column 0x00000000 -> 0x63636363; column 0x52525252 -> 0x00000000.
- INV, column 0x63ED7C16 -> 0x005301FF; round-trip SUB-then-INV of random data returns the input.
- Backpressure: stream 10 tokens with tags 0..9, out_ready toggling 1,0,0,1 pattern:
  - outputs in tag order, none lost or duplicated
  - in_ready low exactly while occupancy = DEPTH and out_ready = 0
- Back-to-back modes SUB, TBL, INV, BYPASS every cycle at full rate -> each result matches its own mode; one output per cycle after DEPTH-cycle fill.
- Assert rst_n low with pipe full -> out_valid and occupancy drop to 0 asynchronously. After release the next token emerges with correct data and no stale token.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types and byte helpers for the substitution pipe
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_SUB    = 2'd0,
    MODE_TBL    = 2'd1,
    MODE_INV    = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_e;

  // Byte idx of a column; byte 0 is the most significant byte.
  function automatic logic [7:0] col_byte(input logic [31:0] col, input int idx);
    return col[(31 - 8 * idx) -: 8];
  endfunction

  // Assemble a column from bytes 0..3, byte 0 in the top position.
  function automatic logic [31:0] make_col(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_byte_lut.sv
// rtl/aes_byte_lut.sv - per-byte S, 2*S and inverse S lookup
module aes_byte_lut (
  input  logic [7:0] din,
  output logic [7:0] s,
  output logic [7:0] xs,
  output logic [7:0] inv_s
);

  // Tables are listed row-major from entry 0x00, so entry n sits at index 255-n.
  localparam logic [255:0][7:0] S_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0][7:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign s     = S_TBL[~din];
  assign inv_s = INV_TBL[~din];
  // The doubled S-box entry is the S output shifted and reduced by the AES polynomial.
  assign xs    = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);

endmodule

// File: rtl/sbox_lookup_pipe.sv
// rtl/sbox_lookup_pipe.sv - pipelined multi-lane AES SubBytes / T-table engine
module sbox_lookup_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_mode,
  input  logic [32*LANES-1:0]        in_data,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [32*LANES-1:0]        out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int W     = 32 * LANES;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [W-1:0] lut_data;

  // Lookup and fold happen before stage 1 so the token is finished at accept.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0]  t  [4];
    logic [7:0]  xt [4];
    logic [7:0]  it [4];
    logic [7:0]  tt [4];
    logic [31:0] col_in;
    logic [31:0] col_res;

    assign col_in = in_data[32*k +: 32];

    for (genvar j = 0; j < 4; j++) begin : g_byte
      aes_byte_lut u_lut (
        .din   (col_byte(col_in, j)),
        .s     (t[j]),
        .xs    (xt[j]),
        .inv_s (it[j])
      );
      assign tt[j] = xt[j] ^ t[j];
    end

    // Per-column result selected by the token mode; TBL is SubBytes then MixColumns.
    always_comb begin
      col_res = col_in;
      case (mode_e'(in_mode))
        MODE_SUB: col_res = make_col(t[0], t[1], t[2], t[3]);
        MODE_TBL: col_res = make_col(xt[0] ^ tt[1] ^ t[2]  ^ t[3],
                                     t[0]  ^ xt[1] ^ tt[2] ^ t[3],
                                     t[0]  ^ t[1]  ^ xt[2] ^ tt[3],
                                     tt[0] ^ t[1]  ^ t[2]  ^ xt[3]);
        MODE_INV: col_res = make_col(it[0], it[1], it[2], it[3]);
        default:  col_res = col_in;
      endcase
    end

    assign lut_data[32*k +: 32] = col_res;
  end

  logic [DEPTH:1] v;
  logic [DEPTH:1] ld;
  logic [DEPTH:1] nxt_v;
  logic [W-1:0]     data_q   [1:DEPTH];
  logic [TAG_W-1:0] tag_q    [1:DEPTH];
  logic [W-1:0]     nxt_data [1:DEPTH];
  logic [TAG_W-1:0] nxt_tag  [1:DEPTH];
  logic             ld_acc;

  // A stage may load when it is empty or everything downstream of it moves.
  always_comb begin
    ld_acc = out_ready;
    ld     = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      ld_acc = ld_acc | ~v[i];
      ld[i]  = ld_acc;
    end
  end

  // Each stage is fed by the one before it; stage 1 is fed by the lookup.
  always_comb begin
    nxt_v[1]    = in_valid;
    nxt_data[1] = lut_data;
    nxt_tag[1]  = in_tag;
    for (int i = 2; i <= DEPTH; i++) begin
      nxt_v[i]    = v[i-1];
      nxt_data[i] = data_q[i-1];
      nxt_tag[i]  = tag_q[i-1];
    end
  end

  // Stage registers; payload only moves with a valid token so stalled or empty data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 1; i <= DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 1; i <= DEPTH; i++) begin
        if (ld[i]) begin
          v[i] <= nxt_v[i];
          if (nxt_v[i]) begin
            data_q[i] <= nxt_data[i];
            tag_q[i]  <= nxt_tag[i];
          end
        end
      end
    end
  end

  // Occupancy is the count of valid stages.
  always_comb begin
    occupancy = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

  assign in_ready  = ld[1];
  assign out_valid = v[DEPTH];
  assign out_data  = data_q[DEPTH];
  assign out_tag   = tag_q[DEPTH];

endmodule

// File: tb/tb_sbox_lookup_pipe.sv
// tb/tb_sbox_lookup_pipe.sv - directed self-checking bench for sbox_lookup_pipe
module tb_sbox_lookup_pipe;
  import aes_pkg::*;

  localparam int LANES = 4;
  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int W     = 32 * LANES;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [W-1:0]     in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       occupancy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     data;
    int               cyc;
  } obs_t;

  obs_t q[$];

  sbox_lookup_pipe #(.LANES(LANES), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q.push_back('{tag: out_tag, data: out_data, cyc: cyc});
    end
  end

  task automatic push(input logic [1:0] m, input logic [W-1:0] d, input logic [TAG_W-1:0] t);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    in_tag   = t;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) break;
    end
    if (n > 100) begin
      checks++;
      errors++;
      $display("FAIL push_timeout tag %0d never accepted", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_q(input int n, input string name);
    int k;
    k = 0;
    while (q.size() < n && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    checks++;
    if (q.size() < n) begin
      errors++;
      $display("FAIL %s_count got %0d outputs want %0d", name, q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_sub();
    logic [W-1:0] exp_d;
    exp_d = 128'h63636363_EDEDEDED_63631616_7C777BF2;
    q.delete();
    out_ready = 1'b1;
    push(MODE_SUB, 128'h00000000_53535353_0000FFFF_01020304, 4'h1);
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL sub_occ_fill got %0d want 1", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_early_valid got %b want 0", out_valid); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_latency_valid got %b want 1", out_valid); end
    checks++; if (out_data !== exp_d) begin errors++; $display("FAIL sub_data got %h want %h", out_data, exp_d); end
    checks++; if (out_tag !== 4'h1) begin errors++; $display("FAIL sub_tag got %h want 1", out_tag); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL sub_occ_out got %0d want 1", occupancy); end
    @(posedge clk);
    #1;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL sub_occ_drain got %0d want 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_valid_drain got %b want 0", out_valid); end
  endtask

  task automatic test_tbl();
    logic [31:0]  c3;
    logic [W-1:0] exp_d;
    c3    = {gf_xtime(8'h63), 8'h63, 8'h63, gf_xtime(8'h63) ^ 8'h63};
    exp_d = {c3, 32'h63636363, 32'h00000000, 32'hC66363A5};
    q.delete();
    out_ready = 1'b1;
    push(MODE_TBL, 128'h00525252_00000000_52525252_00525252, 4'h2);
    wait_q(1, "tbl");
    if (q.size() > 0) begin
      checks++; if (q[0].data !== exp_d) begin errors++; $display("FAIL tbl_data got %h want %h", q[0].data, exp_d); end
      checks++; if (q[0].tag !== 4'h2) begin errors++; $display("FAIL tbl_tag got %h want 2", q[0].tag); end
    end
  endtask

  task automatic test_inv();
    logic [W-1:0] exp_d;
    logic [W-1:0] x;
    logic [W-1:0] y;
    exp_d = 128'h005301FF_52525252_48484848_00000000;
    q.delete();
    out_ready = 1'b1;
    push(MODE_INV, 128'h63ED7C16_00000000_52525252_63636363, 4'h3);
    wait_q(1, "inv");
    if (q.size() > 0) begin
      checks++; if (q[0].data !== exp_d) begin errors++; $display("FAIL inv_data got %h want %h", q[0].data, exp_d); end
    end
    for (int r = 0; r < 3; r++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      q.delete();
      push(MODE_SUB, x, 4'(r));
      wait_q(1, "roundtrip_sub");
      y = (q.size() > 0) ? q[0].data : '0;
      q.delete();
      push(MODE_INV, y, 4'(r));
      wait_q(1, "roundtrip_inv");
      if (q.size() > 0) begin
        checks++; if (q[0].data !== x) begin errors++; $display("FAIL roundtrip got %h want %h", q[0].data, x); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    pat = 4'b1001;
    q.delete();
    fork
      begin
        for (int t = 0; t < 10; t++) begin
          push(MODE_BYPASS, {32{4'(t)}}, 4'(t));
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          out_ready = pat[3 - (c % 4)];
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      begin
        int           mocc;
        logic         exp_rdy;
        logic         pv;
        logic         pr;
        logic [W-1:0] pd;
        mocc = 0;
        pv   = 1'b0;
        pr   = 1'b1;
        pd   = '0;
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          exp_rdy = !((mocc == DEPTH) && !out_ready);
          checks++; if (occupancy !== 2'(mocc)) begin errors++; $display("FAIL bp_occ cycle %0d got %0d want %0d", c, occupancy, mocc); end
          checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want %b", c, in_ready, exp_rdy); end
          if (pv && !pr) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== pd) begin
              errors++;
              $display("FAIL bp_stall_hold cycle %0d got %b/%h want 1/%h", c, out_valid, out_data, pd);
            end
          end
          pv = out_valid;
          pr = out_ready;
          pd = out_data;
          mocc = mocc + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
        end
      end
    join
    wait_q(10, "bp");
    repeat (4) @(posedge clk);
    #1;
    checks++; if (q.size() != 10) begin errors++; $display("FAIL bp_total got %0d want 10", q.size()); end
    for (int i = 0; i < 10; i++) begin
      if (q.size() > i) begin
        checks++;
        if (q[i].tag !== 4'(i) || q[i].data !== {32{4'(i)}}) begin
          errors++;
          $display("FAIL bp_order index %0d got tag %0d data %h want tag %0d", i, q[i].tag, q[i].data, i);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    logic [W-1:0] exp_d [4];
    int           a0;
    d        = 128'h00525252_52525252_00000000_63ED7C16;
    exp_d[0] = 128'h63000000_00000000_63636363_FB551047;
    exp_d[1] = 128'hC66363A5_00000000_63636363_452647DD;
    exp_d[2] = 128'h52484848_48484848_52525252_005301FF;
    exp_d[3] = d;
    q.delete();
    out_ready = 1'b1;
    push(MODE_SUB, d, 4'h0);
    a0 = cyc;
    push(MODE_TBL, d, 4'h1);
    push(MODE_INV, d, 4'h2);
    push(MODE_BYPASS, d, 4'h3);
    wait_q(4, "b2b");
    for (int i = 0; i < 4; i++) begin
      if (q.size() > i) begin
        checks++; if (q[i].data !== exp_d[i]) begin errors++; $display("FAIL b2b_data mode %0d got %h want %h", i, q[i].data, exp_d[i]); end
        checks++; if (q[i].cyc !== a0 + DEPTH - 1 + i) begin errors++; $display("FAIL b2b_timing index %0d got cycle %0d want %0d", i, q[i].cyc, a0 + DEPTH - 1 + i); end
      end
    end
  endtask

  task automatic test_reset_flush();
    q.delete();
    out_ready = 1'b0;
    push(MODE_SUB, 128'h11111111_22222222_33333333_44444444, 4'h5);
    push(MODE_SUB, 128'h55555555_66666666_77777777_88888888, 4'h6);
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_full_occ got %0d want 2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_ready got %b want 0", in_ready); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_async_valid got %b want 0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_async_occ got %0d want 0", occupancy); end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    q.delete();
    push(MODE_TBL, 128'h00525252_00525252_00525252_00525252, 4'h7);
    wait_q(1, "flush_after");
    repeat (5) @(posedge clk);
    #1;
    checks++; if (q.size() != 1) begin errors++; $display("FAIL flush_stale got %0d outputs want 1", q.size()); end
    if (q.size() > 0) begin
      checks++;
      if (q[0].tag !== 4'h7 || q[0].data !== {4{32'hC66363A5}}) begin
        errors++;
        $display("FAIL flush_next got tag %h data %h want tag 7 data %h", q[0].tag, q[0].data, {4{32'hC66363A5}});
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_tbl();
    test_inv();
    test_backpressure();
    test_back_to_back();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
